// File: rtl/warp_pkg.sv
// warp_pkg: shared types and constants for the warp instruction fetch path
//   fetch_state_e           fetch engine states
//   FIFO_DEPTH              default instruction FIFO depth
//   INST_BYTES              bytes per instruction word
//   MAX_OUTSTANDING_DEFAULT default bound on in-flight memory reads
package warp_pkg;
   localparam int FIFO_DEPTH = 16;
   localparam int INST_BYTES = 4;
   localparam int MAX_OUTSTANDING_DEFAULT = 4;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ABORT} fetch_state_e;
endpackage

// File: rtl/warp_inst_fifo.sv
// warp_inst_fifo: show-ahead instruction FIFO with synchronous clear
//   clk, rst           clock, async active-high reset
//   push, push_data    write an entry
//   pop                consume head (ignored when empty)
//   clear              empty the FIFO; beats same-cycle push/pop
//   data               head entry, 0 when empty
//   count, full, empty occupancy status
module warp_inst_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       clear,
   output logic [WIDTH-1:0]           data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign do_push = push && !clear;
   assign do_pop = pop && !empty && !clear;
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign data = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= push_data;
   // the fetch engine's credit rule keeps pushes away from a full FIFO
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !clear));
endmodule

// File: rtl/warp_inst_fetch.sv
// warp_inst_fetch: kernel instruction fetcher feeding a show-ahead FIFO
//   clk, rst                          clock, async active-high reset
//   fetch_start/addr/length           launch a fetch of length words at addr (IDLE only)
//   flush                             abort any fetch and empty the FIFO
//   fetch_busy/done/error             status, done/error are one-cycle pulses
//   mem_rd_req/addr/ready             read request channel
//   mem_rd_valid/data/err             in-order read response channel
//   fifo_pop/data/valid/empty/full/count  instruction FIFO consumer side
module warp_inst_fetch #(
   parameter int FIFO_DEPTH = warp_pkg::FIFO_DEPTH,
   parameter int MAX_OUTSTANDING = warp_pkg::MAX_OUTSTANDING_DEFAULT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            fetch_start,
   input  logic [31:0]                     fetch_addr,
   input  logic [15:0]                     fetch_length,
   input  logic                            flush,
   output logic                            fetch_busy,
   output logic                            fetch_done,
   output logic                            fetch_error,
   output logic                            mem_rd_req,
   output logic [31:0]                     mem_rd_addr,
   input  logic                            mem_rd_ready,
   input  logic                            mem_rd_valid,
   input  logic [31:0]                     mem_rd_data,
   input  logic                            mem_rd_err,
   input  logic                            fifo_pop,
   output logic [31:0]                     fifo_data,
   output logic                            fifo_valid,
   output logic                            fifo_empty,
   output logic                            fifo_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
   import warp_pkg::*;
   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   fetch_state_e state;
   logic [15:0] length, issued, received;
   logic [OW-1:0] outstanding;
   logic err_cause, accept, rsp, push;
   assign fetch_busy = state != IDLE;
   assign fifo_valid = !fifo_empty;
   // credits: never more reads in flight than free FIFO slots
   assign mem_rd_req = state == FETCH && issued < length && 32'(outstanding) < MAX_OUTSTANDING &&
                       32'(fifo_count) + 32'(outstanding) < FIFO_DEPTH;
   assign accept = mem_rd_req && mem_rd_ready;
   assign rsp = mem_rd_valid && outstanding != '0;
   assign push = rsp && !mem_rd_err && !flush && (state == FETCH || state == DRAIN);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         length <= '0;
         issued <= '0;
         received <= '0;
         outstanding <= '0;
         err_cause <= 1'b0;
         fetch_done <= 1'b0;
         fetch_error <= 1'b0;
         mem_rd_addr <= '0;
      end else begin
         fetch_done <= 1'b0;
         fetch_error <= 1'b0;
         outstanding <= outstanding + OW'(accept) - OW'(rsp);
         if (accept) begin
            mem_rd_addr <= mem_rd_addr + 32'(INST_BYTES);
            issued <= issued + 16'd1;
         end
         if (push) received <= received + 16'd1;
         case (state)
            IDLE:
               if (fetch_start) begin
                  mem_rd_addr <= fetch_addr;
                  length <= fetch_length;
                  issued <= '0;
                  received <= '0;
                  if (fetch_length == '0) fetch_done <= 1'b1;
                  else state <= FETCH;
               end
            FETCH, DRAIN:
               if (flush) begin
                  state <= ABORT;
                  err_cause <= 1'b0;
               end else if (rsp && mem_rd_err) begin
                  state <= ABORT;
                  err_cause <= 1'b1;
               end else if (push && received + 16'd1 == length) begin
                  fetch_done <= 1'b1;
                  state <= IDLE;
               end else if (state == FETCH && accept && issued + 16'd1 == length) state <= DRAIN;
            ABORT:
               if (outstanding == '0) begin
                  fetch_error <= err_cause;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   warp_inst_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(mem_rd_data),
      .pop      (fifo_pop),
      .clear    (flush),
      .data     (fifo_data),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );
   // responses must pair with an accepted read
   a_rsp_has_credit: assert property (@(posedge clk) disable iff (rst) !(mem_rd_valid && outstanding == '0));
endmodule

// File: tb/tb_warp_inst_fetch.sv
// tb_warp_inst_fetch: directed and randomized checks of warp_inst_fetch against a queue-based model
module tb_warp_inst_fetch;
   localparam int D = 4;
   localparam int M = 3;
   logic clk = 1'b0;
   logic rst;
   logic fetch_start = 1'b0, flush = 1'b0, mem_rd_ready = 1'b0, mem_rd_valid = 1'b0, mem_rd_err = 1'b0, fifo_pop = 1'b0;
   logic [31:0] fetch_addr = '0, mem_rd_data = '0;
   logic [15:0] fetch_length = '0;
   logic fetch_busy, fetch_done, fetch_error, mem_rd_req, fifo_valid, fifo_empty, fifo_full;
   logic [31:0] mem_rd_addr, fifo_data;
   logic [2:0] fifo_count;
   int checks = 0, errors = 0;
   logic [31:0] q[$], pend_addr[$], addr_log[$];
   int pend_due[$];
   bit m_busy = 0, m_abort = 0, m_errc = 0, e_done = 0, e_err = 0, do_start = 0, do_flush = 0;
   logic [31:0] m_base = '0, s_addr = '0;
   logic [15:0] s_len = '0;
   int m_len = 0, m_issued = 0, m_good = 0, cyc = 0, rsp_n = 0, err_at = -1;
   int ready_pct = 100, pop_pct = 0, lat_min = 1, lat_max = 1, n_done = 0, n_err = 0;

   always #5 clk = ~clk;

   warp_inst_fetch #(.FIFO_DEPTH(D), .MAX_OUTSTANDING(M)) u_dut (
      .clk(clk), .rst(rst), .fetch_start(fetch_start), .fetch_addr(fetch_addr), .fetch_length(fetch_length),
      .flush(flush), .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_error(fetch_error),
      .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_err(mem_rd_err),
      .fifo_pop(fifo_pop), .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
      .fifo_full(fifo_full), .fifo_count(fifo_count)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_checks();
      chk("rst_busy", 32'(fetch_busy), 0);
      chk("rst_req", 32'(mem_rd_req), 0);
      chk("rst_done", 32'(fetch_done), 0);
      chk("rst_err", 32'(fetch_error), 0);
      chk("rst_full", 32'(fifo_full), 0);
      chk("rst_valid", 32'(fifo_valid), 0);
      chk("rst_empty", 32'(fifo_empty), 1);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_data", fifo_data, 0);
      chk("rst_addr", mem_rd_addr, 0);
   endtask

   // one clock: check outputs, drive inputs, advance the reference model
   task automatic tick();
      bit req_exp, acc, rsp, rerr, was_busy, was_abort;
      int out0;
      logic [31:0] raddr;
      @(negedge clk);
      n_done += int'(fetch_done);
      n_err += int'(fetch_error);
      out0 = pend_addr.size();
      chk("count", 32'(fifo_count), 32'(q.size()));
      chk("empty", 32'(fifo_empty), 32'(q.size() == 0));
      chk("valid", 32'(fifo_valid), 32'(q.size() != 0));
      chk("full", 32'(fifo_full), 32'(q.size() == D));
      if (q.size() != 0) chk("head", fifo_data, q[0]);
      chk("busy", 32'(fetch_busy), 32'(m_busy));
      chk("done", 32'(fetch_done), 32'(e_done));
      chk("error", 32'(fetch_error), 32'(e_err));
      chk("credit", 32'(q.size() + out0 <= D && out0 <= M), 1);
      req_exp = m_busy && !m_abort && m_issued < m_len && out0 < M && q.size() + out0 < D;
      chk("req", 32'(mem_rd_req), 32'(req_exp));
      if (mem_rd_req) chk("addr", mem_rd_addr, m_base + 32'(4 * m_issued));
      rsp = out0 != 0 && pend_due[0] <= cyc;
      raddr = rsp ? pend_addr[0] : 32'h0;
      rerr = rsp && rsp_n == err_at;
      mem_rd_ready = $urandom_range(99) < ready_pct;
      fifo_pop = $urandom_range(99) < pop_pct;
      mem_rd_valid = rsp;
      mem_rd_data = rsp ? word(raddr) : 32'h0;
      mem_rd_err = rerr;
      fetch_start = do_start;
      fetch_addr = s_addr;
      fetch_length = s_len;
      flush = do_flush;
      acc = mem_rd_req && mem_rd_ready;
      if (rsp) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
         rsp_n++;
      end
      if (acc) begin
         addr_log.push_back(mem_rd_addr);
         pend_addr.push_back(mem_rd_addr);
         pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
         m_issued++;
      end
      was_busy = m_busy;
      was_abort = m_abort;
      e_done = 0;
      e_err = 0;
      if (do_flush) begin
         q.delete();
         if (m_busy && !m_abort) begin
            m_abort = 1;
            m_errc = 0;
         end
      end else begin
         if (fifo_pop && q.size() != 0) void'(q.pop_front());
         if (rsp && m_busy && !m_abort) begin
            if (rerr) begin
               m_abort = 1;
               m_errc = 1;
            end else begin
               q.push_back(word(raddr));
               m_good++;
               if (m_good == m_len) begin
                  e_done = 1;
                  m_busy = 0;
               end
            end
         end
      end
      if (was_abort && out0 == 0) begin
         m_busy = 0;
         m_abort = 0;
         e_err = m_errc;
      end
      if (!was_busy && do_start) begin
         m_base = s_addr;
         m_len = int'(s_len);
         m_issued = 0;
         m_good = 0;
         rsp_n = 0;
         if (s_len == 0) e_done = 1;
         else m_busy = 1;
      end
      do_start = 0;
      do_flush = 0;
      cyc++;
   endtask

   task automatic start(input logic [31:0] a, input logic [15:0] l);
      n_done = 0;
      n_err = 0;
      addr_log.delete();
      s_addr = a;
      s_len = l;
      do_start = 1;
      tick();
   endtask

   task automatic run_idle(input int limit);
      int n = 0;
      while ((m_busy || pend_addr.size() != 0) && n < limit) begin
         tick();
         n++;
      end
      chk("timeout", 32'(n < limit), 1);
      tick();
   endtask

   task automatic drain();
      pop_pct = 100;
      for (int i = 0; i < D + 2; i++) tick();
      chk("drained", 32'(fifo_count), 0);
      pop_pct = 0;
   endtask

   initial begin
      int n;
      int len;
      logic [31:0] b;
      rst = 1'b1;
      #1;
      reset_checks();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // basic fetch, 1-cycle latency, no pops
      start(32'h1000, 16'd3);
      run_idle(50);
      chk("b_nreq", 32'(addr_log.size()), 3);
      if (addr_log.size() == 3)
         for (int i = 0; i < 3; i++) chk("b_addr", addr_log[i], 32'h1000 + 32'(4 * i));
      chk("b_count", 32'(fifo_count), 3);
      chk("b_head", fifo_data, word(32'h1000));
      chk("b_done", 32'(n_done), 1);
      chk("b_err", 32'(n_err), 0);
      drain();
      // backpressure: FIFO fills, requests stop, popping resumes them
      ready_pct = 70;
      lat_max = 3;
      start(32'h4000, 16'd10);
      repeat (30) tick();
      chk("bp_full", 32'(fifo_count), D);
      chk("bp_req", 32'(mem_rd_req), 0);
      pop_pct = 60;
      run_idle(300);
      chk("bp_nreq", 32'(addr_log.size()), 10);
      chk("bp_done", 32'(n_done), 1);
      drain();
      // memory error on the third response
      ready_pct = 100;
      lat_max = 1;
      err_at = 2;
      start(32'h5000, 16'd8);
      run_idle(100);
      chk("e_count", 32'(fifo_count), 2);
      chk("e_done", 32'(n_done), 0);
      chk("e_err", 32'(n_err), 1);
      err_at = -1;
      drain();
      // flush with two reads in flight
      lat_min = 3;
      lat_max = 3;
      start(32'h6000, 16'd12);
      tick();
      tick();
      chk("f_outstanding", 32'(pend_addr.size()), 2);
      ready_pct = 0;
      do_flush = 1;
      tick();
      tick();
      chk("f_empty", 32'(fifo_empty), 1);
      ready_pct = 100;
      run_idle(50);
      chk("f_done", 32'(n_done), 0);
      chk("f_err", 32'(n_err), 0);
      lat_min = 1;
      lat_max = 1;
      // zero length
      start(32'h7000, 16'd0);
      tick();
      chk("z_done", 32'(n_done), 1);
      tick();
      chk("z_nreq", 32'(addr_log.size()), 0);
      // address wrap
      pop_pct = 100;
      start(32'hFFFF_FFFC, 16'd2);
      run_idle(50);
      chk("w_nreq", 32'(addr_log.size()), 2);
      if (addr_log.size() == 2) begin
         chk("w_addr0", addr_log[0], 32'hFFFF_FFFC);
         chk("w_addr1", addr_log[1], 32'h0000_0000);
      end
      chk("w_done", 32'(n_done), 1);
      // start while busy is ignored
      pop_pct = 50;
      ready_pct = 80;
      lat_max = 2;
      start(32'h2000, 16'd6);
      tick();
      tick();
      s_addr = 32'h9000;
      s_len = 16'd2;
      do_start = 1;
      tick();
      run_idle(200);
      chk("s_nreq", 32'(addr_log.size()), 6);
      if (addr_log.size() == 6) chk("s_last", addr_log[5], 32'h2014);
      chk("s_done", 32'(n_done), 1);
      drain();
      // asynchronous reset while draining
      ready_pct = 100;
      lat_min = 3;
      lat_max = 3;
      start(32'h3000, 16'd4);
      n = 0;
      while (!(m_issued == 4 && pend_addr.size() != 0) && n < 40) begin
         tick();
         n++;
      end
      chk("r_reach", 32'(n < 40), 1);
      @(posedge clk);
      #1;
      chk("r_busy_pre", 32'(fetch_busy), 1);
      #1 rst = 1'b1;
      #1;
      reset_checks();
      q.delete();
      pend_addr.delete();
      pend_due.delete();
      m_busy = 0;
      m_abort = 0;
      e_done = 0;
      e_err = 0;
      mem_rd_valid = 1'b0;
      mem_rd_err = 1'b0;
      mem_rd_ready = 1'b0;
      fifo_pop = 1'b0;
      fetch_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      // randomized fetches, one with an injected error
      for (int k = 0; k < 4; k++) begin
         ready_pct = int'($urandom_range(100, 40));
         pop_pct = int'($urandom_range(90, 20));
         lat_min = 1;
         lat_max = int'($urandom_range(4, 1));
         len = int'($urandom_range(20, 1));
         err_at = (k == 2) ? int'($urandom_range(len - 1, 0)) : -1;
         b = $urandom();
         b[1:0] = 2'b00;
         start(b, 16'(len));
         run_idle(600);
         chk("rnd_done", 32'(n_done), 32'(err_at < 0));
         chk("rnd_err", 32'(n_err), 32'(err_at >= 0));
         err_at = -1;
         drain();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/warp_inst_fetch.md
# warp_inst_fetch

Instruction fetch engine and instruction FIFO that sit directly upstream of the warp controller. It reads a kernel of 32-bit instructions from memory starting at a byte address and buffers them in a show-ahead FIFO. The controller pops instructions from that FIFO. A credit scheme bounds outstanding reads so the FIFO never overflows.

## Interface
- FIFO_DEPTH, warp_pkg::FIFO_DEPTH (16): instruction FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 4: maximum accepted memory reads without a response; 1..FIFO_DEPTH.
- clk  in  1  clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- fetch_start  in  1  one-cycle request; latches fetch_addr/fetch_length; ignored unless IDLE.
- fetch_addr  in  32  kernel base byte address.
- fetch_length  in  16  instruction count.
- flush  in  1  abort fetch and empty the FIFO.
- fetch_busy  out  1  state ≠ IDLE.
- fetch_done  out  1  one-cycle pulse when all instructions have been pushed.
- fetch_error  out  1  one-cycle pulse on memory error completion.
- mem_rd_req  out  1  read request valid.
- mem_rd_addr  out  32  read byte address.
- mem_rd_ready  in  1  request accepted when req && ready.
- mem_rd_valid  in  1  response valid; in-order, always accepted.
- mem_rd_data  in  32  response instruction.
- mem_rd_err  in  1  response error, qualified by valid.
- fifo_pop  in  1  consume head.
- fifo_data  out  32  head entry (show-ahead).
- fifo_valid  out  1  = !fifo_empty.
- fifo_empty  out  1  no entries.
- fifo_full  out  1  FIFO_DEPTH entries.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy.

## Operation
- States: IDLE, FETCH, DRAIN, ABORT.
- IDLE + fetch_start: latch addr/length; issued=0, received=0.
  - length 0: stay IDLE and pulse fetch_done next cycle.
  - Otherwise go to FETCH.
- FETCH:
  - mem_rd_req = (issued < length) && (outstanding < MAX_OUTSTANDING) && (fifo_count + outstanding < FIFO_DEPTH).
  - mem_rd_addr = base + 4·issued, 32-bit wrap, no error on wrap.
  - On accept, issued increments.
  - When issued == length, go to DRAIN.
- DRAIN: wait until received == length, then pulse fetch_done and go to IDLE.
- Response without error: push mem_rd_data and increment received.
- Response with mem_rd_err: data dropped; go to ABORT; no further requests.
- ABORT: discard all responses; when outstanding == 0, pulse fetch_error (error cause) or nothing (flush cause), then go to IDLE.
- flush (any state):
  - FIFO cleared that cycle.
  - In FETCH or DRAIN, go to ABORT. In IDLE, only the FIFO clears.
  - flush wins over a same-cycle push or pop.
- Pop on empty: ignored. Push and pop in the same cycle: count unchanged; a push to a full FIFO is impossible by credit rule and is covered by an assertion.
- A response with no outstanding read is ignored and covered by an assertion.
- outstanding = accepted requests − responses, width $clog2(MAX_OUTSTANDING+1).

## Timing
- Reset values:
  - state IDLE.
  - mem_rd_req, fetch_busy, fetch_done, fetch_error, fifo_full, fifo_valid = 0.
  - fifo_empty = 1.
  - fifo_count, fifo_data, mem_rd_addr = 0.
- fetch_start at cycle N: mem_rd_req may assert in N+1.
- Read accepted in cycle N: mem_rd_addr advances in N+1.
- Response in cycle N: entry visible on fifo_data/fifo_valid in N+1.
- Last push in cycle N: fetch_done pulses in N+1.
- mem_rd_req and mem_rd_addr are registered-state functions with no combinational path from mem_rd_ready. mem_rd_req may drop without acceptance when credits vanish.
- Reset mid-operation: all state cleared immediately. Later responses are ignored.

## Structure
- warp_pkg additions:
  - fetch_state_e (IDLE/FETCH/DRAIN/ABORT).
  - INST_BYTES = 4.
  - MAX_OUTSTANDING_DEFAULT = 4.
- Sub-module warp_inst_fifo: synchronous show-ahead FIFO with push/pop/clear, data/count/full/empty, pointers wrapping at FIFO_DEPTH.
- Top level holds the FSM, counters, credit logic and address generator.

## Test plan
- Basic fetch: base 0x1000, length 3, mem always ready, 1-cycle latency → reads 0x1000/0x1004/0x1008, FIFO holds 3 in order, one fetch_done pulse, IDLE.
- Backpressure: FIFO_DEPTH 4, length 10, no pops until full → fifo_count never >4 and outstanding+count ≤4. Popping resumes requests, all 10 arrive in order.
- Error: length 8, response 3 has mem_rd_err → 2 entries pushed, no new requests. After outstanding drains, fetch_error pulses once and fetch_done never pulses.
- Flush mid-fetch: flush with 2 outstanding → FIFO empty next cycle. The 2 late responses are discarded. IDLE with no done or error pulse.
- Edge cases:
  - length 0 → fetch_done next cycle with no requests.
  - base 0xFFFF_FFFC, length 2 → addresses 0xFFFF_FFFC, 0x0000_0000.
  - fetch_start while busy ignored.
  - Reset asserted mid-DRAIN clears all outputs asynchronously.
